// File: rtl/one2three.sv
`default_nettype none
// ----------------------------------------------------------------------------
// one2three : buffers one frame and replays it three times, tagging each copy
//             with ID 1/2/3 in the low nibble of byte WHEREISID.
// Revision  : 1.0
// ----------------------------------------------------------------------------
module one2three #(
  parameter int WHEREISID  = 0,
  parameter int GAP_CYCLES = 12,
  parameter int ADDR_W     = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_in,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       en_out,
  output logic [1:0] copy_id,
  output logic       busy,
  output logic       err
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam int                CW       = ADDR_W + 1;
  localparam int                GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0]     ID_POS   = CW'(WHEREISID);
  localparam logic [CW-1:0]     FULL     = CW'(DEPTH);
  localparam logic [CW-1:0]     ONE      = CW'(1);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    SEND    = 3'd2,
    GAP     = 3'd3,
    CHECK   = 3'd4
  } state_t;

  state_t            state, state_n;
  logic [CW-1:0]     wr_cnt, wr_cnt_n, len, len_n;
  logic [CW-1:0]     rd_addr, rd_addr_n, rd_k, rd_k_n;
  logic [GAP_W-1:0]  gap_cnt, gap_cnt_n;
  logic [1:0]        copy_n;
  logic              busy_n, err_n, trunc, trunc_n;
  logic              rd_vld, rd_vld_n, en_prev, ignore, ignore_n;
  logic              we;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        mem [DEPTH];
  logic [7:0]        rd_data;
  logic              in_busy;

  assign in_busy = (state != IDLE) && (state != CAPTURE);

  always_comb begin
    state_n   = state;
    wr_cnt_n  = wr_cnt;
    len_n     = len;
    rd_addr_n = rd_addr;
    rd_k_n    = rd_k;
    gap_cnt_n = gap_cnt;
    copy_n    = copy_id;
    busy_n    = busy;
    trunc_n   = trunc;
    err_n     = 1'b0;
    rd_vld_n  = 1'b0;
    we        = 1'b0;
    wr_addr   = wr_cnt[ADDR_W-1:0];
    // A burst that started while busy stays ignored until en_in drops,
    // so its tail can never be mistaken for a new frame in IDLE.
    ignore_n  = en_in && (ignore || in_busy);
    if (en_in && !en_prev && in_busy) err_n = 1'b1;

    case (state)
      IDLE: begin
        if (en_in && !ignore) begin
          we       = 1'b1;
          wr_addr  = '0;
          wr_cnt_n = ONE;
          busy_n   = 1'b1;
          trunc_n  = 1'b0;
          copy_n   = 2'd0;
          state_n  = CAPTURE;
        end
      end
      CAPTURE: begin
        if (en_in) begin
          if (wr_cnt == FULL) begin
            trunc_n = 1'b1;
          end else begin
            we       = 1'b1;
            wr_cnt_n = wr_cnt + ONE;
          end
        end else begin
          len_n = wr_cnt;
          if (wr_cnt <= ID_POS) begin
            err_n   = 1'b1;
            busy_n  = 1'b0;
            state_n = IDLE;
          end else begin
            err_n     = trunc;
            copy_n    = 2'd1;
            rd_addr_n = '0;
            state_n   = SEND;
          end
        end
      end
      SEND: begin
        rd_vld_n  = 1'b1;
        rd_k_n    = rd_addr;
        rd_addr_n = rd_addr + ONE;
        gap_cnt_n = '0;
        if (rd_addr == len - ONE) state_n = GAP;
      end
      GAP: begin
        gap_cnt_n = gap_cnt + GAP_ONE;
        if (gap_cnt == GAP_LAST) begin
          if (copy_id == 2'd3) begin
            state_n = CHECK;
          end else begin
            copy_n    = copy_id + 2'd1;
            rd_addr_n = '0;
            state_n   = SEND;
          end
        end
      end
      CHECK: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      wr_cnt   <= '0;
      len      <= '0;
      rd_addr  <= '0;
      rd_k     <= '0;
      gap_cnt  <= '0;
      copy_id  <= 2'd0;
      busy     <= 1'b0;
      err      <= 1'b0;
      trunc    <= 1'b0;
      rd_vld   <= 1'b0;
      en_prev  <= 1'b0;
      ignore   <= 1'b0;
      en_out   <= 1'b0;
      data_out <= 8'h00;
    end else begin
      state    <= state_n;
      wr_cnt   <= wr_cnt_n;
      len      <= len_n;
      rd_addr  <= rd_addr_n;
      rd_k     <= rd_k_n;
      gap_cnt  <= gap_cnt_n;
      copy_id  <= copy_n;
      busy     <= busy_n;
      err      <= err_n;
      trunc    <= trunc_n;
      rd_vld   <= rd_vld_n;
      en_prev  <= en_in;
      ignore   <= ignore_n;
      en_out   <= rd_vld;
      if (!rd_vld)
        data_out <= 8'h00;
      else if (rd_k == ID_POS)
        data_out <= {rd_data[7:4], 2'b00, copy_id};
      else
        data_out <= rd_data;
    end
  end

  // Frame buffer: one write port for capture, one registered read port for replay.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= data_in;
    rd_data <= mem[rd_addr[ADDR_W-1:0]];
  end

endmodule
`default_nettype wire

// File: tb/tb_one2three.sv
`default_nettype none
// tb_one2three : table-driven and randomized frames checked against a queue
//                model of the three-copy replay, plus multi-cycle corner cases.
`timescale 1ns/1ps
module tb_one2three;

  localparam int GAP   = 12;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int WID_A = 3;
  localparam int WID_B = 0;

  logic       clk     = 1'b0;
  logic       rst     = 1'b0;
  logic       en_in   = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       sel     = 1'b0;

  logic       en_in_a, en_in_b;
  logic [7:0] data_out_a, data_out_b;
  logic       en_out_a, en_out_b, busy_a, busy_b, err_a, err_b;
  logic [1:0] copy_id_a, copy_id_b;

  assign en_in_a = en_in & ~sel;
  assign en_in_b = en_in & sel;

  one2three #(.WHEREISID(WID_A), .GAP_CYCLES(GAP), .ADDR_W(AW)) dut_a (
    .clk(clk), .rst(rst), .en_in(en_in_a), .data_in(data_in),
    .data_out(data_out_a), .en_out(en_out_a), .copy_id(copy_id_a),
    .busy(busy_a), .err(err_a)
  );

  one2three #(.WHEREISID(WID_B), .GAP_CYCLES(GAP), .ADDR_W(AW)) dut_b (
    .clk(clk), .rst(rst), .en_in(en_in_b), .data_in(data_in),
    .data_out(data_out_b), .en_out(en_out_b), .copy_id(copy_id_b),
    .busy(busy_b), .err(err_b)
  );

  always #5 clk = ~clk;

  logic [7:0] m_data;
  logic       m_en, m_busy, m_err;
  logic [1:0] m_id;
  assign m_data = sel ? data_out_b : data_out_a;
  assign m_en   = sel ? en_out_b   : en_out_a;
  assign m_busy = sel ? busy_b     : busy_a;
  assign m_err  = sel ? err_b      : err_a;
  assign m_id   = sel ? copy_id_b  : copy_id_a;

  // ---------------- monitor ----------------
  typedef struct { logic [7:0] d; logic [1:0] id; int c; } rec_t;
  rec_t out_q[$];
  int   err_q[$];
  int   cyc    = 0;
  int   bfall  = -1;
  int   dz_bad = 0;
  logic busy_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (m_en) out_q.push_back('{m_data, m_id, cyc});
    else if (m_data != 8'h00) dz_bad++;
    if (m_err) err_q.push_back(cyc);
    if (busy_q && !m_busy) bfall = cyc;
    busy_q = m_busy;
  end

  // ---------------- scoring ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // ---------------- reference model ----------------
  logic [7:0] frame[$];
  logic [7:0] exp_d[$];
  logic [1:0] exp_id[$];

  task automatic build_model(input int wid);
    int len;
    logic [7:0] b;
    exp_d.delete();
    exp_id.delete();
    len = (frame.size() > DEPTH) ? DEPTH : frame.size();
    if (len <= wid) return;
    for (int id = 1; id <= 3; id++) begin
      for (int k = 0; k < len; k++) begin
        b = frame[k];
        if (k == wid) b = {b[7:4], 2'b00, 2'(id)};
        exp_d.push_back(b);
        exp_id.push_back(2'(id));
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  int t_low, t_first;

  task automatic clear_mon();
    out_q.delete();
    err_q.delete();
    bfall  = -1;
    dz_bad = 0;
  endtask

  task automatic rand_frame(input int n);
    frame.delete();
    for (int i = 0; i < n; i++) frame.push_back(8'($urandom));
  endtask

  task automatic drive_frame();
    foreach (frame[i]) begin
      @(negedge clk);
      if (i == 0) t_first = cyc + 1;
      en_in   = 1'b1;
      data_in = frame[i];
    end
    @(negedge clk);
    en_in   = 1'b0;
    data_in = 8'h00;
    t_low   = cyc + 1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (m_busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({name, " idle timeout"}, int'(n < 400), 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_copy2(input string name);
    int n = 0;
    while (!(m_en && m_id == 2'd2) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, " reach copy 2"}, int'(n < 200), 1);
  endtask

  task automatic verify(input string name, input int copy_len, input int n_err);
    int last;
    build_model(sel ? WID_B : WID_A);
    check({name, " byte count"}, out_q.size(), 3 * copy_len);
    for (int i = 0; i < out_q.size() && i < exp_d.size(); i++)
      check($sformatf("%s byte %0d {id,data}", name, i),
            int'({out_q[i].id, out_q[i].d}), int'({exp_id[i], exp_d[i]}));
    if (out_q.size() > 0) begin
      check({name, " first en_out cycle"}, out_q[0].c, t_low + 2);
      for (int i = 1; i < out_q.size(); i++)
        check($sformatf("%s spacing %0d", name, i), out_q[i].c - out_q[i-1].c,
              (copy_len > 0 && i % copy_len == 0) ? GAP + 1 : 1);
      last = out_q[out_q.size()-1].c;
      check({name, " busy fall cycle"}, bfall, last + GAP);
    end else begin
      check({name, " busy fall cycle"}, bfall, t_low);
    end
    check({name, " err count"}, err_q.size(), n_err);
    check({name, " data zero when idle"}, dz_bad, 0);
  endtask

  // ---------------- test ----------------
  typedef struct { int n; int copy_len; int n_err; } vec_t;
  vec_t vecs[7];

  logic [7:0] f1[$];
  int         t1, c_last, guard, rn, rl;

  initial begin
    vecs[0] = '{8,  8,  0};
    vecs[1] = '{3,  0,  1};
    vecs[2] = '{20, 16, 1};
    vecs[3] = '{4,  4,  0};
    vecs[4] = '{16, 16, 0};
    vecs[5] = '{17, 16, 1};
    vecs[6] = '{1,  0,  1};

    repeat (3) @(negedge clk);
    check("reset en_out",   int'(en_out_a),   0);
    check("reset data_out", int'(data_out_a), 0);
    check("reset copy_id",  int'(copy_id_a),  0);
    check("reset busy",     int'(busy_a),     0);
    check("reset err",      int'(err_a),      0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Fixed 8-byte frame 0x10..0x17, ID byte at offset 3
    clear_mon();
    frame.delete();
    for (int i = 0; i < 8; i++) frame.push_back(8'(8'h10 + i));
    drive_frame();
    wait_idle("spec8");
    verify("spec8", 8, 0);
    if (out_q.size() >= 24) begin
      check("spec8 copy1 id byte", int'(out_q[3].d),  8'h11);
      check("spec8 copy2 id byte", int'(out_q[11].d), 8'h12);
      check("spec8 copy3 id byte", int'(out_q[19].d), 8'h13);
    end

    // Table of lengths with random payloads
    for (int v = 0; v < 7; v++) begin
      clear_mon();
      rand_frame(vecs[v].n);
      drive_frame();
      wait_idle($sformatf("vec%0d", v));
      verify($sformatf("vec%0d", v), vecs[v].copy_len, vecs[v].n_err);
      if (vecs[v].n_err > 0 && err_q.size() > 0)
        check($sformatf("vec%0d err cycle", v), err_q[0], t_low);
    end

    // Random lengths; expectation from the length rules alone
    for (int r = 0; r < 4; r++) begin
      rn = $urandom_range(1, 22);
      rl = (rn > DEPTH) ? DEPTH : rn;
      clear_mon();
      rand_frame(rn);
      drive_frame();
      wait_idle($sformatf("rand%0d", r));
      verify($sformatf("rand%0d", r), (rl > WID_A) ? rl : 0,
             (rn <= WID_A || rn > DEPTH) ? 1 : 0);
    end

    // Second frame offered during copy 2 is dropped
    clear_mon();
    rand_frame(6);
    drive_frame();
    f1 = frame;
    t1 = t_low;
    wait_copy2("traffic");
    rand_frame(5);
    drive_frame();
    frame = f1;
    t_low = t1;
    wait_idle("traffic");
    verify("traffic", 6, 1);
    if (err_q.size() > 0) check("traffic err cycle", err_q[0], t_first);
    clear_mon();
    rand_frame(7);
    drive_frame();
    wait_idle("after traffic");
    verify("after traffic", 7, 0);

    // en_in rises on the cycle CHECK returns to IDLE
    clear_mon();
    rand_frame(4);
    drive_frame();
    guard = 0;
    while (out_q.size() < 12 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("check-edge copies seen", int'(out_q.size() >= 12), 1);
    c_last = (out_q.size() > 0) ? out_q[out_q.size()-1].c : cyc;
    guard = 0;
    while (cyc < c_last + 11 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    en_in   = 1'b1;
    data_in = 8'h5A;
    repeat (3) @(negedge clk);
    en_in   = 1'b0;
    data_in = 8'h00;
    repeat (30) @(negedge clk);
    check("check-edge busy stays low", int'(m_busy), 0);
    verify("check-edge", 4, 1);
    if (err_q.size() > 0) check("check-edge err cycle", err_q[0], c_last + 12);

    // Reset during copy 2, then a clean frame
    clear_mon();
    rand_frame(6);
    drive_frame();
    wait_copy2("reset");
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("mid reset en_out",  int'(en_out_a),  0);
    check("mid reset busy",    int'(busy_a),    0);
    check("mid reset copy_id", int'(copy_id_a), 0);
    check("mid reset err",     int'(err_a),     0);
    repeat (4) @(negedge clk);
    clear_mon();
    rand_frame(5);
    drive_frame();
    wait_idle("post reset");
    verify("post reset", 5, 0);

    // Single-byte frames on the WHEREISID=0 instance
    sel = 1'b1;
    repeat (2) @(negedge clk);
    for (int r = 0; r < 3; r++) begin
      clear_mon();
      frame.delete();
      frame.push_back(8'hAF);
      drive_frame();
      wait_idle($sformatf("len1_%0d", r));
      verify($sformatf("len1_%0d", r), 1, 0);
      if (out_q.size() == 3) begin
        check($sformatf("len1_%0d copy1", r), int'(out_q[0].d), 8'hA1);
        check($sformatf("len1_%0d copy2", r), int'(out_q[1].d), 8'hA2);
        check($sformatf("len1_%0d copy3", r), int'(out_q[2].d), 8'hA3);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

endmodule
`default_nettype wire
